// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM for a multi-cycle RV32I core.
//
// It steps the shared datapath through fetch, decode, execute, memory and
// writeback. It drives every datapath enable and mux select, resolves the
// branch outcome from the ALU zero flag, and counts retired instructions.
//
// State | meaning
// ------+-----------------------------------------------------------
// 0     | FETCH    : read instruction, PC += 4, load IR when ready
// 1     | DECODE   : ALUOut <= old_pc + imm (branch target); dispatch
// 2     | EXEC_R   : reg A op reg B
// 3     | EXEC_I   : reg A op imm
// 4     | MEM_ADDR : reg A + imm (load/store address)
// 5     | MEM_RD   : data read; hold until mem_ready
// 6     | MEM_WR   : data write; hold until mem_ready, then retire
// 7     | WB_MEM   : rd <= memory data register, retire
// 8     | WB_ALU   : rd <= ALUOut, retire
// 9     | BRANCH   : compare reg A - reg B, PC <= ALUOut if taken, retire
// 10    | LUI      : rd <= 0 + imm, retire
// 15    | TRAP     : unsupported opcode; parked until reset
//
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   opcode_i, funct3_i, funct7b5_i    instruction fields from IR
//   zero_i                            ALU zero flag
//   mem_ready_i                       memory access completes this cycle
//   pc_write_o ... reg_write_o        datapath strobes (forced 0 in reset)
//   alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o   mux selects
//   branch_o, branch_taken_o          branch state / outcome
//   illegal_o                         sticky unsupported-opcode flag
//   state_o                           current state, for debug
//   instret_o                         retired-instruction count

module multicycle_ctrl #(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           opcode_i,
    input  logic [2:0]           funct3_i,
    input  logic                 funct7b5_i,
    input  logic                 zero_i,
    input  logic                 mem_ready_i,
    output logic                 pc_write_o,
    output logic                 ir_write_o,
    output logic                 mem_read_o,
    output logic                 mem_write_o,
    output logic                 reg_write_o,
    output logic [1:0]           alu_src_a_o,
    output logic [1:0]           alu_src_b_o,
    output logic [3:0]           alu_op_o,
    output logic [1:0]           result_src_o,
    output logic                 branch_o,
    output logic                 branch_taken_o,
    output logic                 illegal_o,
    output logic [3:0]           state_o,
    output logic [INSTRET_W-1:0] instret_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_MEM   = 4'd7,
        S_WB_ALU   = 4'd8,
        S_BRANCH   = 4'd9,
        S_LUI      = 4'd10,
        S_TRAP     = 4'd15
    } state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;

    state_e                 state_q, state_d;
    logic                   illegal_q, illegal_d;
    logic [INSTRET_W-1:0]   instret_q, instret_d;
    logic                   retire;

    // Raw strobes before reset gating
    logic pc_write_s, ir_write_s, mem_read_s, mem_write_s, reg_write_s;

    // funct7b5 selects SUB/SRA; for I-type, funct3=000 has an immediate
    // in bit 30, so only the shift alternate applies there.
    function automatic logic [3:0] alu_decode(input logic [2:0] f3,
                                              input logic       f7b5,
                                              input logic       allow_sub);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (f7b5 && allow_sub) ? ALU_SUB : ALU_ADD;
            3'b001:  op = 4'd2;
            3'b010:  op = 4'd3;
            3'b011:  op = 4'd4;
            3'b100:  op = 4'd5;
            3'b101:  op = f7b5 ? 4'd7 : 4'd6;
            3'b110:  op = 4'd8;
            default: op = 4'd9;
        endcase
        return op;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready_i) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode_i)
                    OP_R:               state_d = S_EXEC_R;
                    OP_I:               state_d = S_EXEC_I;
                    OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
                    OP_BRANCH:          state_d = (funct3_i[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
                    OP_LUI:             state_d = S_LUI;
                    default:            state_d = S_TRAP;
                endcase
            end
            S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
            S_MEM_ADDR: state_d = (opcode_i == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready_i) state_d = S_WB_MEM;
            S_MEM_WR:   if (mem_ready_i) state_d = S_FETCH;
            S_WB_MEM, S_WB_ALU, S_BRANCH, S_LUI: state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_TRAP;
        endcase
    end

    // Only the final step of an instruction returns to FETCH, so any
    // transition into FETCH is a retirement.
    assign retire    = (state_d == S_FETCH) && (state_q != S_FETCH);
    assign instret_d = retire ? instret_q + INSTRET_W'(1) : instret_q;
    assign illegal_d = illegal_q | (state_d == S_TRAP);

    always_comb begin
        pc_write_s     = 1'b0;
        ir_write_s     = 1'b0;
        mem_read_s     = 1'b0;
        mem_write_s    = 1'b0;
        reg_write_s    = 1'b0;
        alu_src_a_o    = 2'd0;
        alu_src_b_o    = 2'd0;
        alu_op_o       = ALU_ADD;
        result_src_o   = 2'd0;
        branch_o       = 1'b0;
        branch_taken_o = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read_s   = 1'b1;
                alu_src_b_o  = 2'd2;
                result_src_o = 2'd2;
                ir_write_s   = mem_ready_i;
                pc_write_s   = mem_ready_i;
            end
            S_DECODE: begin
                alu_src_a_o = 2'd1;
                alu_src_b_o = 2'd1;
            end
            S_EXEC_R: begin
                alu_src_a_o = 2'd2;
                alu_op_o    = alu_decode(funct3_i, funct7b5_i, 1'b1);
            end
            S_EXEC_I: begin
                alu_src_a_o = 2'd2;
                alu_src_b_o = 2'd1;
                alu_op_o    = alu_decode(funct3_i, funct7b5_i, 1'b0);
            end
            S_MEM_ADDR: begin
                alu_src_a_o = 2'd2;
                alu_src_b_o = 2'd1;
            end
            S_MEM_RD:   mem_read_s  = 1'b1;
            S_MEM_WR:   mem_write_s = 1'b1;
            S_WB_MEM: begin
                reg_write_s  = 1'b1;
                result_src_o = 2'd1;
            end
            S_WB_ALU:   reg_write_s = 1'b1;
            S_BRANCH: begin
                branch_o       = 1'b1;
                alu_src_a_o    = 2'd2;
                alu_op_o       = ALU_SUB;
                branch_taken_o = funct3_i[0] ? ~zero_i : zero_i;
                pc_write_s     = funct3_i[0] ? ~zero_i : zero_i;
            end
            S_LUI: begin
                alu_src_a_o  = 2'd3;
                alu_src_b_o  = 2'd1;
                reg_write_s  = 1'b1;
                result_src_o = 2'd2;
            end
            default: ;
        endcase
    end

    // Strobes are gated directly by rst_n so an asserted reset kills any
    // in-flight write before the state register has been cleared.
    assign pc_write_o  = pc_write_s  & rst_n;
    assign ir_write_o  = ir_write_s  & rst_n;
    assign mem_read_o  = mem_read_s  & rst_n;
    assign mem_write_o = mem_write_s & rst_n;
    assign reg_write_o = reg_write_s & rst_n;

    assign illegal_o = illegal_q;
    assign state_o   = state_q;
    assign instret_o = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: scripted instruction sequences push the
// expected per-cycle outputs into a scoreboard queue; a negedge process
// pops and compares them against the DUT.

module tb_multicycle_ctrl;

    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [6:0]    opcode = '0;
    logic [2:0]    funct3 = '0;
    logic          funct7b5 = 1'b0;
    logic          zero = 1'b0;
    logic          mem_ready = 1'b0;
    logic          pc_write, ir_write, mem_read, mem_write, reg_write;
    logic [1:0]    alu_src_a, alu_src_b, result_src;
    logic [3:0]    alu_op, state;
    logic          branch, branch_taken, illegal;
    logic [IW-1:0] instret;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [21:0] outs;
        logic [3:0]  ic;
    } exp_t;

    exp_t       sb_q[$];
    logic [3:0] exp_ic = '0;
    logic [21:0] obs_vec;

    always #5 clk = ~clk;

    multicycle_ctrl #(.INSTRET_W(IW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .opcode_i       (opcode),
        .funct3_i       (funct3),
        .funct7b5_i     (funct7b5),
        .zero_i         (zero),
        .mem_ready_i    (mem_ready),
        .pc_write_o     (pc_write),
        .ir_write_o     (ir_write),
        .mem_read_o     (mem_read),
        .mem_write_o    (mem_write),
        .reg_write_o    (reg_write),
        .alu_src_a_o    (alu_src_a),
        .alu_src_b_o    (alu_src_b),
        .alu_op_o       (alu_op),
        .result_src_o   (result_src),
        .branch_o       (branch),
        .branch_taken_o (branch_taken),
        .illegal_o      (illegal),
        .state_o        (state),
        .instret_o      (instret)
    );

    assign obs_vec = {state, pc_write, ir_write, mem_read, mem_write, reg_write,
                      alu_src_a, alu_src_b, alu_op, result_src,
                      branch, branch_taken, illegal};

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected output vector, same field order as obs_vec
    function automatic logic [21:0] ov(input logic [3:0] st, input logic pcw, input logic irw,
                                       input logic mr, input logic mw, input logic rw,
                                       input logic [1:0] sa, input logic [1:0] sbs,
                                       input logic [3:0] op, input logic [1:0] rs,
                                       input logic br, input logic bt, input logic ill);
        return {st, pcw, irw, mr, mw, rw, sa, sbs, op, rs, br, bt, ill};
    endfunction

    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk_val({e.tag, "_outs"}, 32'(obs_vec), 32'(e.outs));
            chk_val({e.tag, "_instret"}, 32'(instret), 32'(e.ic));
        end
    end

    task automatic cyc(input string tag, input logic rdy, input logic z, input logic [21:0] v);
        exp_t e;
        mem_ready = rdy;
        zero      = z;
        e.tag = tag; e.outs = v; e.ic = exp_ic;
        sb_q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic set_ir(input logic [31:0] ir);
        opcode   = ir[6:0];
        funct3   = ir[14:12];
        funct7b5 = ir[30];
    endtask

    task automatic do_fetch(input int waits);
        for (int i = 0; i < waits; i++)
            cyc("fetch_wait", 1'b0, 1'b0, ov(0,0,0,1,0,0,0,2,0,2,0,0,0));
        cyc("fetch", 1'b1, 1'b0, ov(0,1,1,1,0,0,0,2,0,2,0,0,0));
        cyc("decode", 1'b1, 1'b0, ov(1,0,0,0,0,0,1,1,0,0,0,0,0));
    endtask

    task automatic do_wb_alu();
        cyc("wb_alu", 1'b1, 1'b0, ov(8,0,0,0,0,1,0,0,0,0,0,0,0));
        exp_ic++;
    endtask

    task automatic do_lui();
        set_ir(32'h000010B7);
        do_fetch(0);
        cyc("lui", 1'b1, 1'b0, ov(10,0,0,0,0,1,3,1,0,2,0,0,0));
        exp_ic++;
    endtask

    task automatic release_rst();
        mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset state, strobes forced low while FETCH is decoded
        #2;
        chk_val("rst_state", 32'(state), 32'd0);
        chk_val("rst_mem_read", 32'(mem_read), 32'd0);
        chk_val("rst_illegal", 32'(illegal), 32'd0);
        chk_val("rst_instret", 32'(instret), 32'd0);
        @(posedge clk); #1;
        release_rst();

        // add x3,x1,x2
        set_ir(32'h002081B3);
        do_fetch(0);
        cyc("add_ex", 1'b1, 1'b0, ov(2,0,0,0,0,0,2,0,0,0,0,0,0));
        do_wb_alu();

        // sub x3,x1,x2
        set_ir(32'h402081B3);
        do_fetch(0);
        cyc("sub_ex", 1'b1, 1'b0, ov(2,0,0,0,0,0,2,0,1,0,0,0,0));
        do_wb_alu();

        // srai x1,x2,3
        set_ir(32'h40315093);
        do_fetch(0);
        cyc("srai_ex", 1'b1, 1'b0, ov(3,0,0,0,0,0,2,1,7,0,0,0,0));
        do_wb_alu();

        // addi x1,x0,-1024 (IR[30]=1 must not turn into SUB)
        set_ir(32'hC0000093);
        do_fetch(0);
        cyc("addi_ex", 1'b1, 1'b0, ov(3,0,0,0,0,0,2,1,0,0,0,0,0));
        do_wb_alu();

        // lw with two wait cycles in MEM_RD: 7 cycles total
        set_ir(32'h00012083);
        do_fetch(0);
        cyc("lw_addr", 1'b1, 1'b0, ov(4,0,0,0,0,0,2,1,0,0,0,0,0));
        cyc("lw_rd_wait", 1'b0, 1'b0, ov(5,0,0,1,0,0,0,0,0,0,0,0,0));
        cyc("lw_rd_wait", 1'b0, 1'b0, ov(5,0,0,1,0,0,0,0,0,0,0,0,0));
        cyc("lw_rd", 1'b1, 1'b0, ov(5,0,0,1,0,0,0,0,0,0,0,0,0));
        cyc("lw_wb", 1'b1, 1'b0, ov(7,0,0,0,0,1,0,0,0,1,0,0,0));
        exp_ic++;

        // sw with one fetch wait and one write wait
        set_ir(32'h00112023);
        do_fetch(1);
        cyc("sw_addr", 1'b1, 1'b0, ov(4,0,0,0,0,0,2,1,0,0,0,0,0));
        cyc("sw_wr_wait", 1'b0, 1'b0, ov(6,0,0,0,1,0,0,0,0,0,0,0,0));
        cyc("sw_wr", 1'b1, 1'b0, ov(6,0,0,0,1,0,0,0,0,0,0,0,0));
        exp_ic++;

        // beq zero=1 taken, bne zero=1 not taken, beq zero=0 not taken
        set_ir(32'h00208063);
        do_fetch(0);
        cyc("beq_z1", 1'b1, 1'b1, ov(9,1,0,0,0,0,2,0,1,0,1,1,0));
        exp_ic++;
        set_ir(32'h00209063);
        do_fetch(0);
        cyc("bne_z1", 1'b1, 1'b1, ov(9,0,0,0,0,0,2,0,1,0,1,0,0));
        exp_ic++;
        set_ir(32'h00208063);
        do_fetch(0);
        cyc("beq_z0", 1'b1, 1'b0, ov(9,0,0,0,0,0,2,0,1,0,1,0,0));
        exp_ic++;

        do_lui();
        cyc("post_lui", 1'b0, 1'b0, ov(0,0,0,1,0,0,0,2,0,2,0,0,0));

        // Reset asserted while MEM_WR is waiting on memory
        set_ir(32'h00112023);
        do_fetch(0);
        cyc("sw2_addr", 1'b1, 1'b0, ov(4,0,0,0,0,0,2,1,0,0,0,0,0));
        mem_ready = 1'b0;
        #1;
        chk_val("mw_before_rst", 32'(mem_write), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_val("mw_async_drop", 32'(mem_write), 32'd0);
        chk_val("mw_rst_state", 32'(state), 32'd0);
        chk_val("mw_rst_instret", 32'(instret), 32'd0);
        @(negedge clk);
        chk_val("rst_fetch_no_read", 32'(mem_read), 32'd0);
        exp_ic = '0;
        @(posedge clk); #1;
        release_rst();

        // 16 retirements wrap a 4-bit counter back to 0
        for (int i = 0; i < 16; i++) do_lui();
        cyc("wrap_fetch", 1'b0, 1'b0, ov(0,0,0,1,0,0,0,2,0,2,0,0,0));
        chk_val("wrap_instret", 32'(instret), 32'd0);

        // One retire so the frozen count is nonzero, then illegal opcode
        set_ir(32'h002081B3);
        do_fetch(0);
        cyc("add2_ex", 1'b1, 1'b0, ov(2,0,0,0,0,0,2,0,0,0,0,0,0));
        do_wb_alu();
        set_ir(32'h0000007F);
        do_fetch(0);
        for (int i = 0; i < 20; i++)
            cyc("trap", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ov(15,0,0,0,0,0,0,0,0,0,0,0,1));

        rst_n = 1'b0;
        #1;
        chk_val("trap_rst_state", 32'(state), 32'd0);
        chk_val("trap_rst_illegal", 32'(illegal), 32'd0);
        chk_val("trap_rst_instret", 32'(instret), 32'd0);
        exp_ic = '0;
        @(posedge clk); #1;
        release_rst();
        cyc("final_fetch", 1'b0, 1'b0, ov(0,0,0,1,0,0,0,2,0,2,0,0,0));

        chk_val("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
